// File: rtl/fifo_read_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter; optional counters under RD_STREAM_STATS_EN.
// Latency: FIFO_RD_EN in cycle N gives M_VALID in cycle N+2; one word per cycle sustained.
// Backpressure: a 3-entry skid buffer absorbs the read latency; reads stop when buffer plus in-flight reaches 3.
module fifo_read_stream_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  RD_CLK,
    input  logic                  RD_RSTN,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  FIFO_RD_EN,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [15:0]           XFER_CNT,
    output logic [15:0]           STALL_CNT
`endif
);

    typedef enum logic [1:0] {
        EMPTY_S,
        PART_S,
        FULL_S
    } state_t;

    state_t                r_state;
    logic [1:0]            r_count;
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [0:2];

    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic [1:0]            w_next_count;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_push = r_inflight;
    assign w_pop  = M_VALID & M_READY;
    assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};

    // Issue decision uses only registered occupancy, never M_READY.
    assign FIFO_RD_EN = RD_RSTN & ~FIFO_EMPTY & (w_occ < 3'd3);

    assign M_VALID = (r_state != EMPTY_S);
    assign M_DATA  = r_buf[r_head];

    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + 2'd1;
            2'b01:   w_next_count = r_count - 2'd1;
            default: w_next_count = r_count;
        endcase
    end

    always_ff @(posedge RD_CLK or negedge RD_RSTN) begin
        if (!RD_RSTN) begin
            r_state    <= EMPTY_S;
            r_count    <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= FIFO_RD_EN;
            if (w_push) begin
                r_buf[r_tail] <= FIFO_DATA;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= w_next_count;
            case (w_next_count)
                2'd0:    r_state <= EMPTY_S;
                2'd3:    r_state <= FULL_S;
                default: r_state <= PART_S;
            endcase
        end
    end

`ifdef RD_STREAM_STATS_EN
    logic [15:0] r_xfer_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge RD_CLK or negedge RD_RSTN) begin
        if (!RD_RSTN) begin
            r_xfer_cnt  <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (M_VALID && M_READY && (r_xfer_cnt != 16'hFFFF)) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if (M_VALID && !M_READY && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign XFER_CNT  = r_xfer_cnt;
    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench for fifo_read_stream_adapter with a behavioural FIFO read port and stream scoreboard.
module tb_fifo_read_stream_adapter;

    localparam int LOGN = 8192;

    logic       RD_CLK = 1'b0;
    logic       RD_RSTN;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_DATA;
    logic       FIFO_RD_EN;
    logic       M_VALID;
    logic       M_READY;
    logic [7:0] M_DATA;
`ifdef RD_STREAM_STATS_EN
    logic [15:0] XFER_CNT;
    logic [15:0] STALL_CNT;
`endif

    fifo_read_stream_adapter #(.DATA_WIDTH(8)) dut (
        .RD_CLK     (RD_CLK),
        .RD_RSTN    (RD_RSTN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_RD_EN (FIFO_RD_EN),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA)
`ifdef RD_STREAM_STATS_EN
        ,
        .XFER_CNT   (XFER_CNT),
        .STALL_CNT  (STALL_CNT)
`endif
    );

    always #5 RD_CLK = ~RD_CLK;

    // Behavioural FIFO read port: registered data, one-cycle read latency.
    logic [7:0] mem [0:255];
    int         f_rd = 0;
    int         f_wr = 0;
    logic [7:0] f_data = 8'h00;
    logic       gate_empty = 1'b0;
    logic       inf_src = 1'b0;

    assign FIFO_EMPTY = gate_empty | ((f_rd == f_wr) & ~inf_src);
    assign FIFO_DATA  = f_data;

    always @(posedge RD_CLK) begin
        if (FIFO_RD_EN) begin
            f_data <= inf_src ? 8'h5A : mem[f_rd % 256];
            f_rd   <= f_rd + 1;
        end
    end

    // Monitor on the falling edge: values here are what the next rising edge samples.
    int         cyc = 0;
    int         n_rden = 0;
    int         n_empty_viol = 0;
    int         hold_viol = 0;
    logic       rden_log [0:LOGN-1];
    logic       vld_log  [0:LOGN-1];
    logic [7:0] dat_log  [0:LOGN-1];
    logic [7:0] out_q [$];
    int         out_cyc [$];
    logic       p_ok = 1'b0;
    logic       p_vld = 1'b0;
    logic       p_rdy = 1'b0;
    logic [7:0] p_dat = 8'h00;

    always @(negedge RD_CLK) begin
        if (cyc < LOGN) begin
            rden_log[cyc] = FIFO_RD_EN;
            vld_log[cyc]  = M_VALID;
            dat_log[cyc]  = M_DATA;
        end
        if (FIFO_RD_EN) n_rden++;
        if (FIFO_EMPTY && FIFO_RD_EN) n_empty_viol++;
        if (RD_RSTN && M_VALID && M_READY) begin
            out_q.push_back(M_DATA);
            out_cyc.push_back(cyc);
        end
        if (!RD_RSTN) begin
            p_ok = 1'b0;
        end else begin
            if (p_ok && p_vld && !p_rdy && (!M_VALID || (M_DATA != p_dat))) hold_viol++;
            p_ok = 1'b1;
        end
        p_vld = M_VALID;
        p_rdy = M_READY;
        p_dat = M_DATA;
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[f_wr % 256] = d;
        f_wr++;
    endtask

    task automatic tick();
        @(posedge RD_CLK);
        #1;
    endtask

    initial begin
        int base;
        int f;
        int errs;
        int n;

        RD_RSTN = 1'b0;
        M_READY = 1'b0;

        // Held in reset with a non-empty FIFO.
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        repeat (3) tick();
        check_eq("rst_rden", 32'(FIFO_RD_EN), 32'd0);
        check_eq("rst_vld",  32'(M_VALID),    32'd0);
        check_eq("rst_dat",  32'(M_DATA),     32'h00);

        // Three words streamed with M_READY held high.
        out_q.delete();
        out_cyc.delete();
        M_READY = 1'b1;
        base = cyc;
        RD_RSTN = 1'b1;
        repeat (12) tick();
        f = -1;
        for (int i = 0; i < 10; i++) begin
            if (f < 0 && rden_log[base + i] === 1'b1) f = base + i;
        end
        check_eq("t3_rden_seen", 32'(f >= 0), 32'd1);
        if (f < 0) f = base;
        check_eq("t3_rden0", 32'(rden_log[f]),     32'd1);
        check_eq("t3_rden1", 32'(rden_log[f + 1]), 32'd1);
        check_eq("t3_rden2", 32'(rden_log[f + 2]), 32'd1);
        check_eq("t3_rden3", 32'(rden_log[f + 3]), 32'd0);
        check_eq("t3_vld1",  32'(vld_log[f + 1]),  32'd0);
        check_eq("t3_vld2",  32'(vld_log[f + 2]),  32'd1);
        check_eq("t3_vld3",  32'(vld_log[f + 3]),  32'd1);
        check_eq("t3_vld4",  32'(vld_log[f + 4]),  32'd1);
        check_eq("t3_vld5",  32'(vld_log[f + 5]),  32'd0);
        check_eq("t3_dat2",  32'(dat_log[f + 2]),  32'h11);
        check_eq("t3_dat3",  32'(dat_log[f + 3]),  32'h22);
        check_eq("t3_dat4",  32'(dat_log[f + 4]),  32'h33);
        check_eq("t3_nout",  32'(out_q.size()),    32'd3);

        // Asynchronous reset with two words buffered and a read about to issue.
        M_READY = 1'b0;
        push_word(8'hAA);
        push_word(8'hBB);
        repeat (6) tick();
        check_eq("t2_vld_pre", 32'(M_VALID), 32'd1);
        check_eq("t2_dat_pre", 32'(M_DATA),  32'hAA);
        push_word(8'hCC);
        #1;
        check_eq("t2_rden_pre", 32'(FIFO_RD_EN), 32'd1);
        #1;
        RD_RSTN = 1'b0;
        #1;
        check_eq("t2_vld_rst",  32'(M_VALID),    32'd0);
        check_eq("t2_dat_rst",  32'(M_DATA),     32'h00);
        check_eq("t2_rden_rst", 32'(FIFO_RD_EN), 32'd0);
        tick();
        out_q.delete();
        out_cyc.delete();
        M_READY = 1'b1;
        RD_RSTN = 1'b1;
        repeat (6) tick();
        check_eq("t2_nout_after", 32'(out_q.size()), 32'd1);
        check_eq("t2_word_after", 32'((out_q.size() > 0) ? out_q[0] : 8'h00), 32'hCC);

        // Backpressure: five words available, only three fetched while stalled.
        M_READY = 1'b0;
        gate_empty = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        out_q.delete();
        out_cyc.delete();
        tick();
        n_rden = 0;
        gate_empty = 1'b0;
        repeat (10) tick();
        check_eq("t4_nrden",   32'(n_rden),     32'd3);
        check_eq("t4_vld",     32'(M_VALID),    32'd1);
        check_eq("t4_dat",     32'(M_DATA),     32'h11);
        check_eq("t4_rden_lo", 32'(FIFO_RD_EN), 32'd0);
        check_eq("t4_hold",    32'(hold_viol),  32'd0);
        M_READY = 1'b1;
        repeat (10) tick();
        check_eq("t4_nout", 32'(out_q.size()), 32'd5);
        if (out_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("t4_word%0d", i), 32'(out_q[i]), 32'(8'h11 * (i + 1)));
            end
            check_eq("t4_b2b", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
        end

        // Gated FIFO_EMPTY and random M_READY over 200 words.
        out_q.delete();
        out_cyc.delete();
        n_empty_viol = 0;
        hold_viol = 0;
        for (int i = 0; i < 200; i++) push_word(8'((i * 7 + 3) % 256));
        n = 0;
        while (out_q.size() < 200 && n < 4000) begin
            gate_empty = ~gate_empty;
            M_READY = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        gate_empty = 1'b0;
        M_READY = 1'b1;
        repeat (4) tick();
        check_eq("t5_nout", 32'(out_q.size()), 32'd200);
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            if (i >= out_q.size() || out_q[i] !== 8'((i * 7 + 3) % 256)) errs++;
        end
        check_eq("t5_order",      32'(errs),          32'd0);
        check_eq("t5_empty_read", 32'(n_empty_viol),  32'd0);
        check_eq("t5_hold",       32'(hold_viol),     32'd0);
        check_eq("t5_drained",    32'(f_rd == f_wr),  32'd1);

`ifdef RD_STREAM_STATS_EN
        M_READY = 1'b0;
        RD_RSTN = 1'b0;
        tick();
        check_eq("t6_xfer_rst",  32'(XFER_CNT),  32'd0);
        check_eq("t6_stall_rst", 32'(STALL_CNT), 32'd0);
        RD_RSTN = 1'b1;
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        n = 0;
        while (!M_VALID && n < 20) begin
            tick();
            n++;
        end
        check_eq("t6_vld_seen", 32'(M_VALID), 32'd1);
        repeat (3) tick();
        M_READY = 1'b1;
        repeat (10) tick();
        check_eq("t6_xfer",  32'(XFER_CNT),  32'd4);
        check_eq("t6_stall", 32'(STALL_CNT), 32'd3);
        inf_src = 1'b1;
        repeat (70010) tick();
        check_eq("t6_xfer_sat", 32'(XFER_CNT), 32'hFFFF);
        inf_src = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
